// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter
// Shares one single-port data RAM between the CPU port and the MAU (loader/debug)
// port. Each access is arbitrated separately. A read takes an extra response cycle
// to cover the RAM's one-cycle read latency. 'alive' decides who may use the RAM:
// when it is 0 only the MAU is served, and when it is 1 the two ports take turns
// (round-robin).
// Optional feature: define DATA_MEM_ARB_ADDR_CHECK_EN to flag accesses whose byte
// address lies above the RAM window. Such an access is granted, but it never reaches
// the RAM and it gets an error response.

module data_memory_arbiter #(
  parameter int DATA_W   = 32,
  parameter int RAM_AW   = 14,
  parameter int ADDR_LSB = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alive,

  input  logic              cpu_req,
  input  logic [31:0]       cpu_address,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_wren,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,

  input  logic              mau_req,
  input  logic [31:0]       mau_address,
  input  logic [DATA_W-1:0] mau_wdata,
  input  logic              mau_wren,
  output logic              mau_gnt,
  output logic              mau_rvalid,
  output logic [DATA_W-1:0] mau_rdata,
  output logic              mau_err,

  output logic              ram_clk_en,
  output logic [RAM_AW-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int WORD_HI = RAM_AW + ADDR_LSB;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RESP_CPU = 2'd1;
  localparam logic [1:0] RESP_MAU = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_nextState;
  logic              r_rrLast;
  logic              r_err;
  logic [RAM_AW-1:0] r_ramAddress;
  logic [DATA_W-1:0] r_ramData;

  logic              w_idle;
  logic              w_cpuCand;
  logic              w_cpuWin;
  logic              w_mauWin;
  logic              w_anyWin;
  logic              w_cpuOob;
  logic              w_mauOob;
  logic              w_winOob;
  logic              w_winWren;
  logic              w_issue;
  logic [RAM_AW-1:0] w_winAddr;
  logic [DATA_W-1:0] w_winData;
  logic              w_cpuResp;
  logic              w_mauResp;
  logic              w_unusedAddrBits;

`ifdef DATA_MEM_ARB_ADDR_CHECK_EN
  assign w_cpuOob = |cpu_address[31:WORD_HI];
  assign w_mauOob = |mau_address[31:WORD_HI];
`else
  assign w_cpuOob = 1'b0;
  assign w_mauOob = 1'b0;
`endif

  // The byte-offset bits are never used. The upper bits are used only by the range
  // check, so when that check is off the address aliases into the RAM window.
  assign w_unusedAddrBits = ^{cpu_address[ADDR_LSB-1:0], mau_address[ADDR_LSB-1:0],
                              cpu_address[31:WORD_HI], mau_address[31:WORD_HI]};

  // Pick the winner from the registered state and the live requests. Reset blocks every grant.
  // When both ports request, the port that did not win last time gets the RAM.
  assign w_idle    = !reset && (r_state == IDLE);
  assign w_cpuCand = alive && cpu_req;
  assign w_cpuWin  = w_idle && w_cpuCand && (!mau_req || r_rrLast);
  assign w_mauWin  = w_idle && mau_req && (!w_cpuCand || !r_rrLast);
  assign w_anyWin  = w_cpuWin || w_mauWin;

  assign w_winOob  = w_cpuWin ? w_cpuOob : w_mauOob;
  assign w_winWren = w_cpuWin ? cpu_wren : mau_wren;
  assign w_winAddr = w_cpuWin ? cpu_address[WORD_HI-1:ADDR_LSB] : mau_address[WORD_HI-1:ADDR_LSB];
  assign w_winData = w_cpuWin ? cpu_wdata : mau_wdata;
  assign w_issue   = w_anyWin && !w_winOob;

  // A read, or any out-of-range access, moves to the winner's response cycle. Every other path returns to IDLE.
  always_comb begin
    w_nextState = IDLE;
    if (w_anyWin && (!w_winWren || w_winOob)) begin
      w_nextState = w_cpuWin ? RESP_CPU : RESP_MAU;
    end
  end

  // State, round-robin history, error flag, and the held RAM command fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_rrLast     <= 1'b1;
      r_err        <= 1'b0;
      r_ramAddress <= '0;
      r_ramData    <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_anyWin) begin
        r_rrLast <= w_mauWin;
        r_err    <= w_winOob;
      end
      if (w_issue) begin
        r_ramAddress <= w_winAddr;
        r_ramData    <= w_winData;
      end
    end
  end

  assign w_cpuResp = !reset && (r_state == RESP_CPU);
  assign w_mauResp = !reset && (r_state == RESP_MAU);

  assign cpu_gnt    = w_cpuWin;
  assign mau_gnt    = w_mauWin;
  assign cpu_rvalid = w_cpuResp;
  assign mau_rvalid = w_mauResp;
  assign cpu_err    = w_cpuResp && r_err;
  assign mau_err    = w_mauResp && r_err;
  assign cpu_rdata  = (w_cpuResp && !r_err) ? ram_q : '0;
  assign mau_rdata  = (w_mauResp && !r_err) ? ram_q : '0;

  assign ram_clk_en  = w_issue;
  assign ram_wren    = w_issue && w_winWren;
  assign ram_address = reset ? '0 : (w_issue ? w_winAddr : r_ramAddress);
  assign ram_data    = reset ? '0 : (w_issue ? w_winData : r_ramData);

endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb_data_memory_arbiter
// Directed bench for data_memory_arbiter. It contains a behavioural single-port RAM
// with one cycle of read latency. Inputs are driven 1 ns after the rising edge, and
// outputs are sampled on the falling edge. Expected values depend on
// DATA_MEM_ARB_ADDR_CHECK_EN.

module tb_data_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alive;
  logic        cpu_req, cpu_wren, mau_req, mau_wren;
  logic [31:0] cpu_address, cpu_wdata, mau_address, mau_wdata;
  logic        cpu_gnt, cpu_rvalid, cpu_err, mau_gnt, mau_rvalid, mau_err;
  logic [31:0] cpu_rdata, mau_rdata;
  logic        ram_clk_en, ram_wren;
  logic [13:0] ram_address;
  logic [31:0] ram_data;
  logic [31:0] ram_q = '0;

  logic [31:0] mem [0:16383];

  int passCount  = 0;
  int checkCount = 0;
  int writeCount = 0;

`ifdef DATA_MEM_ARB_ADDR_CHECK_EN
  localparam bit CHECK_ON = 1'b1;
`else
  localparam bit CHECK_ON = 1'b0;
`endif

  data_memory_arbiter dut (
    .clk(clk), .reset(reset), .alive(alive),
    .cpu_req(cpu_req), .cpu_address(cpu_address), .cpu_wdata(cpu_wdata), .cpu_wren(cpu_wren),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .mau_req(mau_req), .mau_address(mau_address), .mau_wdata(mau_wdata), .mau_wren(mau_wren),
    .mau_gnt(mau_gnt), .mau_rvalid(mau_rvalid), .mau_rdata(mau_rdata), .mau_err(mau_err),
    .ram_clk_en(ram_clk_en), .ram_address(ram_address), .ram_data(ram_data),
    .ram_wren(ram_wren), .ram_q(ram_q)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Behavioural single-port RAM: a write updates the array, and q returns the old word one cycle later.
  always @(posedge clk) begin
    if (ram_clk_en) begin
      if (ram_wren) mem[ram_address] <= ram_data;
      ram_q <= mem[ram_address];
    end
  end

  // Clear the RAM contents so the first reads are deterministic.
  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = '0;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic cReq, input logic cWren, input logic [31:0] cAddr,
                               input logic [31:0] cData, input logic mReq, input logic mWren,
                               input logic [31:0] mAddr, input logic [31:0] mData);
    cpu_req = cReq; cpu_wren = cWren; cpu_address = cAddr; cpu_wdata = cData;
    mau_req = mReq; mau_wren = mWren; mau_address = mAddr; mau_wdata = mData;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  // Directed scenario sequence.
  initial begin
    logic        expCpu;
    logic [31:0] expData;

    reset = 1'b1;
    alive = 1'b1;
    applyStimulus(1, 0, 32'h0, 32'h0, 1, 0, 32'h0, 32'h0);

    // Both ports request during reset: no grant, and every output stays 0.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_gnt",   {cpu_gnt, mau_gnt}, 0);
      checkOutput("rst_ctl",   {cpu_rvalid, cpu_err, mau_rvalid, mau_err, ram_clk_en, ram_wren}, 0);
      checkOutput("rst_addr",  ram_address, 0);
      checkOutput("rst_data",  ram_data, 0);
      checkOutput("rst_rdata", cpu_rdata | mau_rdata, 0);
      tick;
    end
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rel_cgnt",  cpu_gnt, 1);
    checkOutput("rel_mgnt",  mau_gnt, 0);
    checkOutput("rel_clken", ram_clk_en, 1);
    tick;
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("rel_rvalid", cpu_rvalid, 1);
    checkOutput("rel_rdata",  cpu_rdata, 0);
    tick;

    // CPU writes, then reads back the same word.
    applyStimulus(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("wr_gnt",  cpu_gnt, 1);
    checkOutput("wr_addr", ram_address, 4);
    checkOutput("wr_wren", ram_wren, 1);
    checkOutput("wr_data", ram_data, 32'hDEADBEEF);
    tick;
    applyStimulus(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("rd_gnt",   cpu_gnt, 1);
    checkOutput("rd_addr",  ram_address, 4);
    checkOutput("rd_wren",  ram_wren, 0);
    checkOutput("rd_early", cpu_rvalid, 0);
    tick;
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("rd_rvalid", cpu_rvalid, 1);
    checkOutput("rd_rdata",  cpu_rdata, 32'hDEADBEEF);
    checkOutput("rd_clken",  ram_clk_en, 0);
    checkOutput("rd_hold",   ram_address, 4);
    tick;
    @(negedge clk);
    checkOutput("rd_after_rvalid", cpu_rvalid, 0);
    checkOutput("rd_after_rdata",  cpu_rdata, 0);

    // A lone MAU write makes the MAU the last winner, so the next tie goes to the CPU.
    applyStimulus(0, 0, 32'h0, 32'h0, 1, 1, 32'h40, 32'h55);
    @(negedge clk);
    checkOutput("mwr_gnt",  mau_gnt, 1);
    checkOutput("mwr_addr", ram_address, 14'h10);
    tick;

    // Both ports write continuously: grants alternate C, M, C, M...
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 1, 32'h100, 32'h1000 + i, 1, 1, 32'h200, 32'h2000 + i);
      @(negedge clk);
      expCpu  = ((i % 2) == 0);
      expData = expCpu ? (32'h1000 + i) : (32'h2000 + i);
      checkOutput("rr_cgnt", cpu_gnt, expCpu);
      checkOutput("rr_mgnt", mau_gnt, !expCpu);
      checkOutput("rr_data", ram_data, expData);
      if (ram_clk_en && ram_wren) writeCount++;
      tick;
    end
    checkOutput("rr_writes", writeCount, 8);

    // With alive low only the MAU is served. Raising alive during the MAU response lets the CPU win next.
    alive = 1'b0;
    applyStimulus(1, 0, 32'h10, 32'h0, 1, 0, 32'h40, 32'h0);
    @(negedge clk);
    checkOutput("own_mgnt", mau_gnt, 1);
    checkOutput("own_cgnt", cpu_gnt, 0);
    tick;
    alive = 1'b1;
    @(negedge clk);
    checkOutput("own_mrvalid", mau_rvalid, 1);
    checkOutput("own_mrdata",  mau_rdata, 32'h55);
    checkOutput("own_cgnt2",   cpu_gnt, 0);
    tick;
    @(negedge clk);
    checkOutput("own_cgnt3", cpu_gnt, 1);
    checkOutput("own_mgnt3", mau_gnt, 0);
    checkOutput("own_addr",  ram_address, 4);
    tick;

    // alive drops during the CPU response: the read still completes, and later CPU requests stall.
    alive = 1'b0;
    applyStimulus(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("drop_rvalid", cpu_rvalid, 1);
    checkOutput("drop_rdata",  cpu_rdata, 32'hDEADBEEF);
    checkOutput("drop_mrdata", mau_rdata, 0);
    tick;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("drop_nognt", cpu_gnt, 0);
      tick;
    end

    // Range check: a read above the RAM window.
    alive = 1'b1;
    applyStimulus(1, 1, 32'h0, 32'hCAFE0000, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("rng_wgnt", cpu_gnt, 1);
    tick;
    applyStimulus(1, 0, 32'h0001_0000, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("rng_gnt",   cpu_gnt, 1);
    checkOutput("rng_clken", ram_clk_en, CHECK_ON ? 32'd0 : 32'd1);
    tick;
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("rng_rvalid", cpu_rvalid, 1);
    checkOutput("rng_err",    cpu_err, CHECK_ON ? 32'd1 : 32'd0);
    checkOutput("rng_rdata",  cpu_rdata, CHECK_ON ? 32'h0 : 32'hCAFE0000);
    tick;
    @(negedge clk);
    checkOutput("rng_idle", {cpu_rvalid, cpu_err}, 0);
    checkOutput("rng_idle_rdata", cpu_rdata, 0);
    tick;

    // Reset during a read response drops the response.
    applyStimulus(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("mid_gnt", cpu_gnt, 1);
    tick;
    reset = 1'b1;
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("mid_rvalid", cpu_rvalid, 0);
    checkOutput("mid_rdata",  cpu_rdata, 0);
    tick;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("mid_after",  cpu_rvalid, 0);
    checkOutput("mid_addr",   ram_address, 0);
    tick;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
